// File: rtl/bfp_comp.sv
// bfp_comp: block floating point compressor for 12-RE PRBs (6 x 64-bit words).
// Each PRB becomes one exponent byte followed by 24 w-bit mantissas, bit-packed MSB-first
// into a byte stream. Packets with a method other than BFP pass through with one cycle latency.
// Optional build macro: BFP_COMP_ROUND_EN selects round-half-up with saturation instead of truncation.

module bfp_comp (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    input  logic [31:0] s_axis_tuser,
    output logic        s_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic [31:0] m_axis_tuser,
    input  logic [3:0]  ctrl_ud_comp_meth,
    input  logic [3:0]  ctrl_ud_iq_width,
    input  logic [3:0]  ctrl_fs_offset
);

    typedef enum logic [1:0] {COLLECT, EXP, PACK} state_t;

    state_t        state, state_n;
    logic          rdy, in_pkt, bfp_mode, last_prb, flush, beat, bfp_now;
    logic [4:0]    width, width_now, sig_width;
    logic [31:0]   user_q;
    logic [63:0]   buffer [6];
    logic [2:0]    wcnt, pcnt;
    logic [14:0]   mag_max, beat_mag;
    logic [3:0]    exp_q, exp_calc;
    logic [143:0]  acc, merged;
    logic [7:0]    cnt, total, push_len, last_keep;
    logic [71:0]   push_bits;
    logic [63:0]   word_sel, out_word;
    logic          final_now, emit_full, emit_last;
    logic          unused_fs_offset;

    assign unused_fs_offset = ^ctrl_fs_offset;

    // One's-complement magnitude: minimal signed width of x is bit_len(this) + 1.
    function automatic logic [14:0] magnitude(input logic [15:0] v);
        return v[14:0] ^ {15{v[15]}};
    endfunction

    function automatic logic [4:0] bit_len(input logic [14:0] m);
        logic [4:0] n;
        n = '0;
        for (int unsigned i = 0; i < 15; i++)
            if (m[i]) n = 5'(i + 1);
        return n;
    endfunction

    function automatic logic [15:0] width_mask(input logic [4:0] w);
        return 16'((17'd1 << w) - 17'd1);
    endfunction

    function automatic logic [15:0] mantissa(input logic [15:0] v, input logic [3:0] e,
                                             input logic [4:0] w);
`ifdef BFP_COMP_ROUND_EN
        logic signed [17:0] x, hi, lo;
        x = {{2{v[15]}}, v};
        if (e != 4'd0) x = x + (18'sd1 <<< (e - 4'd1));
        x  = x >>> e;
        hi = (18'sd1 <<< (w - 5'd1)) - 18'sd1;
        lo = -hi - 18'sd1;
        if (x > hi) x = hi;
        else if (x < lo) x = lo;
        return x[15:0] & width_mask(w);
`else
        logic signed [15:0] x;
        x = $signed(v) >>> e;
        return x & width_mask(w);
`endif
    endfunction

    // Packet-level mode/width come from the first beat; later beats reuse the latched copy.
    always_comb begin
        bfp_now   = in_pkt ? bfp_mode : (ctrl_ud_comp_meth == 4'd1);
        width_now = (ctrl_ud_iq_width == 4'd0) ? 5'd16 : {1'b0, ctrl_ud_iq_width};
        beat_mag  = '0;
        for (int unsigned i = 0; i < 4; i++)
            if (magnitude(s_axis_tdata[16*i +: 16]) > beat_mag)
                beat_mag = magnitude(s_axis_tdata[16*i +: 16]);
        sig_width = bit_len(mag_max) + 5'd1;
        exp_calc  = (sig_width > width) ? 4'(sig_width - width) : 4'd0;
    end

    // Next-state and input-ready decode.
    always_comb begin
        state_n       = state;
        s_axis_tready = rdy && (state == COLLECT) && !flush;
        beat          = s_axis_tvalid && s_axis_tready;
        case (state)
            COLLECT: if (beat && bfp_now && (s_axis_tlast || wcnt == 3'd5)) state_n = EXP;
            EXP:     state_n = PACK;
            PACK:    if (pcnt == 3'd5) state_n = COLLECT;
            default: state_n = COLLECT;
        endcase
    end

    // State register, PRB buffer, running magnitude and exponent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= COLLECT;
            rdy      <= 1'b0;
            in_pkt   <= 1'b0;
            bfp_mode <= 1'b0;
            width    <= 5'd16;
            user_q   <= '0;
            wcnt     <= '0;
            pcnt     <= '0;
            mag_max  <= '0;
            exp_q    <= '0;
            last_prb <= 1'b0;
            for (int unsigned i = 0; i < 6; i++) buffer[i] <= '0;
        end else begin
            state <= state_n;
            rdy   <= 1'b1;
            if (beat) begin
                if (!in_pkt) begin
                    bfp_mode <= (ctrl_ud_comp_meth == 4'd1);
                    width    <= width_now;
                    user_q   <= s_axis_tuser;
                end
                in_pkt <= !s_axis_tlast;
                if (bfp_now) begin
                    // A short PRB zero-fills the words it never received.
                    for (int unsigned i = 0; i < 6; i++) begin
                        if (3'(i) == wcnt) buffer[i] <= s_axis_tdata;
                        else if (s_axis_tlast && 3'(i) > wcnt) buffer[i] <= '0;
                    end
                    if (beat_mag > mag_max) mag_max <= beat_mag;
                    if (state_n == EXP) begin
                        wcnt     <= '0;
                        last_prb <= s_axis_tlast;
                    end else begin
                        wcnt <= wcnt + 3'd1;
                    end
                end
            end
            if (state == EXP) begin
                exp_q   <= exp_calc;
                mag_max <= '0;
            end
            if (state == PACK) pcnt <= (pcnt == 3'd5) ? 3'd0 : pcnt + 3'd1;
        end
    end

    // Bit packer: MSB-aligned accumulator; new bits land just below the held ones.
    always_comb begin
        push_bits = '0;
        push_len  = '0;
        word_sel  = buffer[pcnt];
        if (state == PACK) begin
            if (pcnt == 3'd0) begin
                push_bits = 72'(exp_q);
                push_len  = 8'd8;
            end
            for (int unsigned i = 0; i < 4; i++) begin
                push_bits = (push_bits << width) | 72'(mantissa(word_sel[16*i +: 16], exp_q, width));
                push_len  = push_len + 8'(width);
            end
        end
        merged    = acc | (({push_bits, 72'd0} << (8'd72 - push_len)) >> cnt);
        total     = cnt + push_len;
        final_now = flush || (state == PACK && pcnt == 3'd5 && last_prb);
        emit_last = final_now && total != 8'd0 && total <= 8'd64;
        emit_full = !emit_last && total >= 8'd64;
        last_keep = 8'((16'd1 << ((total + 8'd7) >> 3)) - 16'd1);
        for (int unsigned j = 0; j < 8; j++)
            out_word[8*j +: 8] = merged[143 - 8*j -: 8];
    end

    // Packer state update, including the end-of-packet flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            flush <= 1'b0;
        end else if (emit_last) begin
            acc   <= '0;
            cnt   <= '0;
            flush <= 1'b0;
        end else if (emit_full) begin
            acc   <= merged << 64;
            cnt   <= total - 8'd64;
            flush <= final_now;
        end else begin
            acc   <= merged;
            cnt   <= total;
            flush <= 1'b0;
        end
    end

    // Output register: packer beats, or bypass beats delayed by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
        end else begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tkeep  <= '0;
            if (emit_last || emit_full) begin
                m_axis_tdata  <= out_word;
                m_axis_tkeep  <= emit_last ? last_keep : 8'hFF;
                m_axis_tlast  <= emit_last;
                m_axis_tvalid <= 1'b1;
                m_axis_tuser  <= user_q;
            end else if (beat && !bfp_now) begin
                m_axis_tdata  <= s_axis_tdata;
                m_axis_tkeep  <= s_axis_tkeep;
                m_axis_tlast  <= s_axis_tlast;
                m_axis_tvalid <= 1'b1;
                m_axis_tuser  <= s_axis_tuser;
            end
        end
    end

endmodule
